// File: rtl/des_pkg.sv
// Shared constants and helpers for the DES key schedule: PC-1/PC-2
// selection tables, the per-round rotate amounts and the FSM state type.
package des_pkg;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t GEN  = 1'b1;

    // PC-1: entry i names the key_in bit (1 = MSB) that lands in C||D bit i+1
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry i names the C||D bit that lands in subkey bit i+1
    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied before round 1..16 (sums to 28)
    localparam int SHIFT_TABLE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Rotate amount for a 1-based round; out-of-range rounds give 1 (never used)
    function automatic logic [1:0] shift_amount(input logic [4:0] round);
        logic [3:0] idx;
        idx = 4'(round - 5'd1);
        if (round >= 5'd1 && round <= 5'd16) begin
            return 2'(SHIFT_TABLE[idx]);
        end
        return 2'd1;
    endfunction

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 permuted choice: 56-bit C||D to 48-bit round subkey.
// Kept standalone so an unrolled schedule can instantiate one per round.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56] cd,
    output logic [1:48] subkey
);

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign subkey[gi + 1] = cd[PC2_TABLE[gi]];
        end
    endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule. One subkey per accepted handshake, in
// encrypt order (K1..K16) or decrypt order (K16..K1). C and D are
// rotated in place; decrypt starts from the unrotated PC-1 halves,
// which equal C16/D16 because the total rotation is a full 28 bits.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:64] key_in,
    input  logic        decrypt,
    input  logic        start,
    output logic        busy,
    output logic [1:48] subkey_out,
    output logic [4:0]  subkey_num,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        done,
    output logic        key_err
);

    state_t      state_reg, state_next;
    logic [1:28] c_reg, c_next;
    logic [1:28] d_reg, d_next;
    logic [4:0]  count_reg, count_next;
    logic        decrypt_reg, decrypt_next;
    logic        done_reg, done_next;
    logic        key_err_reg, key_err_next;

    logic [1:56] pc1_key;
    logic [1:48] pc2_key;
    logic [7:0]  byte_odd;
    logic        key_bad;

    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[gi + 1] = key_in[PC1_TABLE[gi]];
        end
        // DES keys carry odd parity in every byte
        for (genvar gi = 0; gi < 8; gi++) begin : g_parity
            assign byte_odd[gi] = ^key_in[8*gi + 1 : 8*gi + 8];
        end
    endgenerate

    assign key_bad = ~&byte_odd;

    des_pc2 u_pc2 (
        .cd     ({c_reg, d_reg}),
        .subkey (pc2_key)
    );

    // Next-state logic: load on start, rotate on each transfer
    always_comb begin
        state_next   = state_reg;
        c_next       = c_reg;
        d_next       = d_reg;
        count_next   = count_reg;
        decrypt_next = decrypt_reg;
        done_next    = 1'b0;
        key_err_next = key_err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = GEN;
                    count_next   = 5'd1;
                    decrypt_next = decrypt;
                    key_err_next = CHECK_PARITY ? key_bad : 1'b0;
                    if (decrypt) begin
                        c_next = pc1_key[1:28];
                        d_next = pc1_key[29:56];
                    end else begin
                        c_next = rotl28(pc1_key[1:28], shift_amount(5'd1));
                        d_next = rotl28(pc1_key[29:56], shift_amount(5'd1));
                    end
                end
            end
            GEN: begin
                if (subkey_ready) begin
                    if (count_reg == 5'd16) begin
                        state_next = IDLE;
                        count_next = 5'd0;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count_reg + 5'd1;
                        if (decrypt_reg) begin
                            c_next = rotr28(c_reg, shift_amount(5'd17 - count_reg));
                            d_next = rotr28(d_reg, shift_amount(5'd17 - count_reg));
                        end else begin
                            c_next = rotl28(c_reg, shift_amount(count_reg + 5'd1));
                            d_next = rotl28(d_reg, shift_amount(count_reg + 5'd1));
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            c_reg       <= '0;
            d_reg       <= '0;
            count_reg   <= '0;
            decrypt_reg <= 1'b0;
            done_reg    <= 1'b0;
            key_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            c_reg       <= c_next;
            d_reg       <= d_next;
            count_reg   <= count_next;
            decrypt_reg <= decrypt_next;
            done_reg    <= done_next;
            key_err_reg <= key_err_next;
        end
    end

    assign busy         = (state_reg == GEN);
    assign subkey_valid = (state_reg == GEN);
    assign subkey_out   = subkey_valid ? pc2_key : '0;
    assign subkey_num   = subkey_valid ? (decrypt_reg ? 5'd17 - count_reg : count_reg) : 5'd0;
    assign done         = done_reg;
    assign key_err      = key_err_reg;

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameter CHECK_PARITY, default 0, meaning: 1 enables DES odd-parity checking of key_in bytes.
REQ-002 Clock is one clock, clk, sampled on the rising edge; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  sole clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 key_in  input  [1:64]  DES key; bit 1 is the MSB, numbered as in FIPS 46-3.
REQ-006 decrypt  input  1  sampled with start; 0 emits K1..K16, 1 emits K16..K1.
REQ-007 start  input  1  request a new schedule; accepted only while busy=0.
REQ-008 busy  output  1  schedule in progress.
REQ-009 subkey_out  output  [1:48]  current round subkey, feeding the round stage key input.
REQ-010 subkey_num  output  5  FIPS index (1..16) of the subkey on subkey_out.
REQ-011 subkey_valid  output  1  subkey_out and subkey_num are valid.
REQ-012 subkey_ready  input  1  downstream accepts the subkey; transfer = valid & ready.
REQ-013 done  output  1  one-cycle pulse after the 16th transfer.
REQ-014 key_err  output  1  parity violation flag for the latched key; constant 0 when CHECK_PARITY=0.

Function
REQ-015 FSM states SHALL be IDLE and GEN only.
REQ-016 IDLE + start: latch decrypt and PC-1(key_in). Encrypt loads C,D rotated left by shift(1). Decrypt loads C,D unrotated. Set count=1 and go to GEN.
REQ-017 Shift schedule SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..16; C and D are independent 28-bit rotations.
REQ-018 In GEN, subkey_valid=1, subkey_out=PC-2(C,D) and subkey_num=count (encrypt) or 17-count (decrypt).
REQ-019 First subkey_valid SHALL be asserted the cycle after start is accepted (latency 1).
REQ-020 On transfer, encrypt SHALL rotate C,D left by shift(count+1); decrypt SHALL rotate right by shift(17-count); count increments.
REQ-021 While valid & !ready, subkey_out, subkey_num and internal state SHALL hold stable.
REQ-022 Transfer at count=16: go to IDLE; next cycle done=1, busy=0, subkey_valid=0.
REQ-023 start while busy=1 SHALL be ignored; start in the same cycle as done is accepted.
REQ-024 subkey_out SHALL be all-zero whenever subkey_valid=0.
REQ-025 CHECK_PARITY=1: key_err is registered at start acceptance and is 1 if any key_in byte has even parity. It holds until the next accepted start. The schedule proceeds regardless.
REQ-026 Back-to-back transfers (ready held 1) SHALL complete 16 subkeys in 16 consecutive cycles.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and clear C, D, count, busy, subkey_valid, subkey_out, subkey_num, done and key_err to 0.
REQ-028 Reset mid-schedule SHALL abort without a done pulse; the first start after deassertion behaves as from power-up.

Structure
REQ-029 Package des_pkg SHALL hold the PC-1 and PC-2 tables, the 16-entry shift schedule, and the IDLE/GEN state type.
REQ-030 Combinational PC-2 SHALL be one sub-module, des_pc2 ([1:56] in, [1:48] out), reusable by a future unrolled schedule.
REQ-031 No other sub-modules; the rotations and the FSM are in-line.

Verification
REQ-032 Encrypt with key 133457799BBCDFF1 and ready=1 -> K1=1B02EFFC7072 at cycle+1 with subkey_num=1, then K2=79AED9DBC9E5, and finally K16=CB3D8B0E17F5 with subkey_num=16. done is pulsed 17 cycles after start.
REQ-033 Same key, decrypt=1 -> first subkey CB3D8B0E17F5 (num 16), last 1B02EFFC7072 (num 1). The sequence is the exact reverse of the encrypt run.
REQ-034 Random ready stalls of 0-5 cycles -> subkey_out and subkey_num stable during stalls, 16 transfers, values identical to the unstalled run.
REQ-035 rst_n pulsed low after the 7th transfer -> all outputs 0 asynchronously, no done. A new start then yields K1 again.
REQ-036 start pulsed during GEN -> ignored, sequence unaffected. start in the done cycle -> new schedule begins with K1 valid the next cycle.
REQ-037 CHECK_PARITY=1, key 133457799BBCDFF0 -> key_err=1 and schedule still completes. Key 133457799BBCDFF1 -> key_err=0.
